// File: rtl/shadow_alert_pkg.sv
// Shared types and alert indices for the shadow-register error alert aggregator.
package shadow_alert_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        REQ     = 2'b01,
        WAIT_LO = 2'b10
    } hs_state_e;

    localparam int unsigned AlertRecovIdx = 0;
    localparam int unsigned AlertFatalIdx = 1;
    localparam int unsigned NumAlerts     = 2;

endpackage

// File: rtl/shadow_alert_hs.sv
// One 4-phase alert handshake with event coalescing (pend) and an optional ack
// timeout, enabled by defining SHADOW_ALERT_TIMEOUT_EN.
module shadow_alert_hs
    import shadow_alert_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic evt_i,
    input  logic force_pend_i,
    input  logic ack_i,
    output logic req_o,
    output logic timeout_o
);

    hs_state_e state_q, state_d;
    logic      req_q, req_d;
    logic      pend_q, pend_d;

`ifdef SHADOW_ALERT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                // ack seen here belongs to nobody and is ignored
                if (evt_i || pend_q || force_pend_i) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    pend_d  = 1'b0;
                end
            end
            REQ: begin
                pend_d = pend_q | evt_i | force_pend_i;
                if (ack_i) begin
                    state_d = WAIT_LO;
                    req_d   = 1'b0;
                end
            end
            WAIT_LO: begin
                pend_d = pend_q | evt_i | force_pend_i;
                if (!ack_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

`ifdef SHADOW_ALERT_TIMEOUT_EN
        timeout_d = timeout_q;
        cnt_d     = (state_q != IDLE) ? cnt_q + 1'b1 : '0;
        // Abandon only a stalled handshake; a request is left pending for retry.
        if (state_q != IDLE && state_d == state_q &&
            cnt_q == CntW'(TimeoutCycles - 1)) begin
            state_d   = IDLE;
            req_d     = 1'b0;
            pend_d    = 1'b1;
            timeout_d = 1'b1;
        end
        if (state_d == IDLE) begin
            cnt_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            pend_q    <= 1'b0;
`ifdef SHADOW_ALERT_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            pend_q    <= pend_d;
`ifdef SHADOW_ALERT_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign req_o = req_q;
`ifdef SHADOW_ALERT_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/shadow_err_alert_agg.sv
// Aggregates shadow-register update/storage errors into recoverable and fatal
// alert handshakes; ack timeouts exist only with SHADOW_ALERT_TIMEOUT_EN.
module shadow_err_alert_agg
    import shadow_alert_pkg::*;
#(
    parameter int unsigned NumRegs       = 8,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumRegs-1:0]   err_update_i,
    input  logic [NumRegs-1:0]   err_storage_i,
    input  logic [NumRegs-1:0]   recov_clr_i,
    input  logic [NumAlerts-1:0] alert_test_i,
    output logic                 recov_req_o,
    input  logic                 recov_ack_i,
    output logic                 fatal_req_o,
    input  logic                 fatal_ack_i,
    output logic [NumRegs-1:0]   recov_cause_o,
    output logic [NumRegs-1:0]   fatal_cause_o,
    output logic [NumAlerts-1:0] timeout_o
);

    logic [NumRegs-1:0] recov_cause_q, recov_cause_d;
    logic [NumRegs-1:0] fatal_cause_q, fatal_cause_d;
    logic               recov_evt, fatal_evt;

    // A new error wins over a same-cycle software clear so no event is lost.
    always_comb begin
        recov_cause_d = (recov_cause_q & ~recov_clr_i) | err_update_i;
        fatal_cause_d = fatal_cause_q | err_storage_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            recov_cause_q <= '0;
            fatal_cause_q <= '0;
        end else begin
            recov_cause_q <= recov_cause_d;
            fatal_cause_q <= fatal_cause_d;
        end
    end

    assign recov_evt = (|err_update_i)  | alert_test_i[AlertRecovIdx];
    assign fatal_evt = (|err_storage_i) | alert_test_i[AlertFatalIdx];

    shadow_alert_hs #(
        .TimeoutCycles(TimeoutCycles)
    ) u_recov_hs (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .evt_i       (recov_evt),
        .force_pend_i(1'b0),
        .ack_i       (recov_ack_i),
        .req_o       (recov_req_o),
        .timeout_o   (timeout_o[AlertRecovIdx])
    );

    // A latched storage error keeps the fatal alert re-requesting until reset.
    shadow_alert_hs #(
        .TimeoutCycles(TimeoutCycles)
    ) u_fatal_hs (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .evt_i       (fatal_evt),
        .force_pend_i(|fatal_cause_q),
        .ack_i       (fatal_ack_i),
        .req_o       (fatal_req_o),
        .timeout_o   (timeout_o[AlertFatalIdx])
    );

    assign recov_cause_o = recov_cause_q;
    assign fatal_cause_o = fatal_cause_q;

endmodule
